// File: rtl/level_ctrl.sv
// Whack-a-Mole progression controller: score, misses, level 1..MAX_LEVEL, level-up pause.
// Optional feature macro: LEVEL_BONUS_LIFE_EN (each level-up forgives one miss).
module level_ctrl #(
    parameter int HITS_PER_LEVEL = 10,
    parameter int MAX_MISSES     = 3,
    parameter int MAX_LEVEL      = 8,
    parameter int PAUSE_CYCLES   = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [3:0] level,
    output logic [7:0] score,
    output logic [1:0] misses,
    output logic       level_up,
    output logic       playing,
    output logic       game_over
);

    localparam int PW = $clog2(PAUSE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;

    state_t          state_q, state_d;
    logic [3:0]      level_q, level_d;
    logic [7:0]      score_q, score_d;
    logic [1:0]      misses_q, misses_d;
    logic [7:0]      hit_cnt_q, hit_cnt_d;
    logic [PW-1:0]   pause_cnt_q, pause_cnt_d;
    logic            level_up_q, level_up_d;
    logic            playing_q, playing_d;
    logic            game_over_q, game_over_d;

    logic [8:0]      hit_inc;
    logic [2:0]      misses_inc;

    assign hit_inc    = {1'b0, hit_cnt_q} + 9'd1;
    assign misses_inc = {1'b0, misses_q} + 3'd1;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        score_d     = score_q;
        misses_d    = misses_q;
        hit_cnt_d   = hit_cnt_q;
        pause_cnt_d = pause_cnt_q;
        level_up_d  = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d   = PLAY;
                    level_d   = 4'd1;
                    score_d   = 8'd0;
                    misses_d  = 2'd0;
                    hit_cnt_d = 8'd0;
                end
            end
            PLAY: begin
                if (hit) begin
                    score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    hit_cnt_d = hit_inc[7:0];
                end
                if (miss) begin
                    misses_d = misses_inc[1:0];
                end
                // Game over takes priority over a level-up completed in the same cycle
                if (miss && (misses_inc == 3'(MAX_MISSES))) begin
                    state_d = OVER;
                end else if (hit && (hit_inc == 9'(HITS_PER_LEVEL))) begin
                    hit_cnt_d = 8'd0;
                    if (level_q < 4'(MAX_LEVEL)) begin
                        level_d     = level_q + 4'd1;
                        level_up_d  = 1'b1;
                        state_d     = PAUSE;
                        pause_cnt_d = '0;
`ifdef LEVEL_BONUS_LIFE_EN
                        misses_d = (misses_d == 2'd0) ? 2'd0 : misses_d - 2'd1;
`else
                        misses_d = misses_d;
`endif
                    end
                end
            end
            PAUSE: begin
                if (pause_cnt_q == PW'(PAUSE_CYCLES - 1)) begin
                    state_d     = PLAY;
                    pause_cnt_d = '0;
                end else begin
                    pause_cnt_d = pause_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        playing_d   = (state_d == PLAY);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            level_q     <= 4'd0;
            score_q     <= 8'd0;
            misses_q    <= 2'd0;
            hit_cnt_q   <= 8'd0;
            pause_cnt_q <= '0;
            level_up_q  <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            hit_cnt_q   <= hit_cnt_d;
            pause_cnt_q <= pause_cnt_d;
            level_up_q  <= level_up_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
        end
    end

    assign level     = level_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign level_up  = level_up_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_level_ctrl.sv
// Table-driven bench for level_ctrl with HITS_PER_LEVEL=3, MAX_MISSES=2, PAUSE_CYCLES=4.
module tb_level_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, hit, miss;
    logic [3:0] level;
    logic [7:0] score;
    logic [1:0] misses;
    logic       level_up, playing, game_over;

    int total = 0;
    int bad   = 0;

`ifdef LEVEL_BONUS_LIFE_EN
    localparam logic [1:0] BM = 2'd0;
`else
    localparam logic [1:0] BM = 2'd1;
`endif

    level_ctrl #(
        .HITS_PER_LEVEL(3),
        .MAX_MISSES(2),
        .MAX_LEVEL(8),
        .PAUSE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .hit(hit),
        .miss(miss),
        .level(level),
        .score(score),
        .misses(misses),
        .level_up(level_up),
        .playing(playing),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       st;
        logic       h;
        logic       m;
        logic [3:0] lvl;
        logic [7:0] sc;
        logic [1:0] ms;
        logic       lu;
        logic       pl;
        logic       go;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, st, h, m, input logic [3:0] lvl,
                       input logic [7:0] sc, input logic [1:0] ms,
                       input logic lu, pl, go);
        vec_t v;
        v.rst = rst; v.st = st; v.h = h; v.m = m;
        v.lvl = lvl; v.sc = sc; v.ms = ms; v.lu = lu; v.pl = pl; v.go = go;
        vecs.push_back(v);
    endtask

    function automatic logic [16:0] outs();
        return {level, score, misses, level_up, playing, game_over};
    endfunction

    task automatic step(input logic rst, st, h, m);
        reset = rst; start = st; hit = h; miss = m;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got lvl=%0d sc=%0d ms=%0d lu=%b pl=%b go=%b want lvl=%0d sc=%0d ms=%0d lu=%b pl=%b go=%b",
                     name, act[16:13], act[12:5], act[4:3], act[2], act[1], act[0],
                     exp[16:13], exp[12:5], exp[4:3], exp[2], exp[1], exp[0]);
        end else begin
            $display("ok   %s lvl=%0d sc=%0d ms=%0d lu=%b pl=%b go=%b",
                     name, act[16:13], act[12:5], act[4:3], act[2], act[1], act[0]);
        end
    endtask

    initial begin
        int lvl_m, sc_m, hc_m;
        logic lu_m;

        reset = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;

        //   rst st h  m   lvl sc ms lu pl go
        add(0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0,  0,  0, 0, 0, 0, 0);
        add(1, 0, 1, 0,  0,  0, 0, 0, 0, 0);
        add(1, 1, 0, 0,  1,  0, 0, 0, 1, 0);
        add(1, 0, 1, 0,  1,  1, 0, 0, 1, 0);
        add(1, 0, 1, 0,  1,  2, 0, 0, 1, 0);
        add(1, 0, 1, 0,  2,  3, 0, 1, 0, 0);
        add(1, 0, 1, 0,  2,  3, 0, 0, 0, 0);
        add(1, 1, 1, 0,  2,  3, 0, 0, 0, 0);
        add(1, 0, 0, 1,  2,  3, 0, 0, 0, 0);
        add(1, 0, 0, 0,  2,  3, 0, 0, 1, 0);
        add(1, 1, 0, 0,  2,  3, 0, 0, 1, 0);
        add(1, 0, 0, 1,  2,  3, 1, 0, 1, 0);
        add(1, 0, 0, 1,  2,  3, 2, 0, 0, 1);
        add(1, 1, 0, 0,  1,  0, 0, 0, 1, 0);
        add(1, 0, 0, 1,  1,  0, 1, 0, 1, 0);
        add(1, 0, 0, 1,  1,  0, 2, 0, 0, 1);
        add(1, 0, 1, 0,  1,  0, 2, 0, 0, 1);
        add(1, 0, 1, 1,  1,  0, 2, 0, 0, 1);
        add(1, 1, 0, 0,  1,  0, 0, 0, 1, 0);
        add(1, 0, 0, 1,  1,  0, 1, 0, 1, 0);
        add(1, 0, 1, 0,  1,  1, 1, 0, 1, 0);
        add(1, 0, 1, 0,  1,  2, 1, 0, 1, 0);
        add(1, 0, 1, 1,  1,  3, 2, 0, 0, 1);
        add(1, 1, 0, 0,  1,  0, 0, 0, 1, 0);
        add(1, 0, 0, 1,  1,  0, 1, 0, 1, 0);
        add(1, 0, 1, 0,  1,  1, 1, 0, 1, 0);
        add(1, 0, 1, 0,  1,  2, 1, 0, 1, 0);
        add(1, 0, 1, 0,  2,  3, BM, 1, 0, 0);
        add(1, 0, 0, 0,  2,  3, BM, 0, 0, 0);
        add(1, 0, 0, 0,  2,  3, BM, 0, 0, 0);
        add(1, 0, 0, 0,  2,  3, BM, 0, 0, 0);
        add(1, 0, 0, 0,  2,  3, BM, 0, 1, 0);
        add(1, 0, 1, 0,  2,  4, BM, 0, 1, 0);
        add(1, 0, 1, 0,  2,  5, BM, 0, 1, 0);
        add(1, 0, 1, 0,  3,  6, BM, 1, 0, 0);
        add(0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0,  0,  0, 0, 0, 0, 0);
        add(1, 1, 0, 0,  1,  0, 0, 0, 1, 0);
        add(1, 0, 0, 1,  1,  0, 1, 0, 1, 0);
        add(1, 0, 0, 1,  1,  0, 2, 0, 0, 1);
        add(0, 1, 0, 0,  0,  0, 0, 0, 0, 0);
        add(1, 1, 0, 0,  1,  0, 0, 0, 1, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].h, vecs[i].m);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].lvl, vecs[i].sc, vecs[i].ms, vecs[i].lu, vecs[i].pl, vecs[i].go});
        end

        // Long run from a fresh level-1 game: level caps at 8, score saturates at 255
        lvl_m = 1; sc_m = 0; hc_m = 0;
        for (int i = 1; i <= 260; i++) begin
            step(1, 0, 1, 0);
            sc_m = (sc_m < 255) ? sc_m + 1 : 255;
            hc_m++;
            lu_m = 1'b0;
            if (hc_m == 3) begin
                hc_m = 0;
                if (lvl_m < 8) begin
                    lvl_m++;
                    lu_m = 1'b1;
                end
            end
            check($sformatf("hit%0d", i), outs(),
                  {4'(lvl_m), 8'(sc_m), 2'd0, lu_m, ~lu_m, 1'b0});
            if (lu_m) begin
                for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
                check($sformatf("resume%0d", i), outs(),
                      {4'(lvl_m), 8'(sc_m), 2'd0, 1'b0, 1'b1, 1'b0});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
